io_port_stream_endpoint: RTL and testbench

//  Device-side end of one Data_Memory I/O port pair. Accepts processor I/O writes
//  (io_wren + word) into a TX FIFO drained by an external valid/ready stream.

---
 rtl/io_port_stream_endpoint.sv | 188 ++++++++++++++++++
 tb/tb_io_port_stream_endpoint.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_stream_endpoint.sv
// -----------------------------------------------------------------------------
// io_port_stream_endpoint
//
// Device-side end of one Data_Memory I/O port pair.
//   TX path : processor I/O writes (cpu_wren + cpu_write_data) are queued in a
//             circular FIFO and drained by an external valid/ready consumer
//             (out_valid / out_ready / out_data).
//   RX path : an external valid/ready producer (in_valid / in_ready / in_data)
//             fills a second circular FIFO whose head word is presented
//             first-word-fall-through on cpu_read_data and popped by cpu_rden.
//   Full/empty flags are exported so upstream logic can annul or stall
//   I/O accesses.
//
// Ports
//   clock           sole clock, all state updates on posedge
//   reset           synchronous, active-high
//   cpu_wren        push request into TX FIFO
//   cpu_write_data  word to push into TX FIFO
//   cpu_write_full  TX FIFO full
//   cpu_rden        pop request from RX FIFO
//   cpu_read_data   RX head word, 0 when empty
//   cpu_read_empty  RX FIFO empty
//   out_valid       TX head valid
//   out_ready       external consumer accepts TX head
//   out_data        TX head word, 0 when empty
//   in_valid        external producer offers a word
//   in_ready        RX FIFO can accept a word
//   in_data         offered word
//   overflow        sticky: cpu_wren seen while TX full
//   underflow       sticky: cpu_rden seen while RX empty
//
// Build option
//   IO_ENDPOINT_ERROR_FLAGS_EN : when defined, overflow/underflow are sticky
//   flops cleared only by reset. When undefined they are tied to 0 and no
//   flops are built. Drop-on-full and return-0-on-empty behaviour is the
//   same either way.
//
// Every output is a function of registered state and reset only; no data or
// handshake input reaches an output combinationally.
// -----------------------------------------------------------------------------
module io_port_stream_endpoint #(
  parameter int WORD_WIDTH = 36,
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_wren,
  input  logic [WORD_WIDTH-1:0] cpu_write_data,
  output logic                  cpu_write_full,
  input  logic                  cpu_rden,
  output logic [WORD_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_read_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  // ---------------------------------------------------------------------------
  // TX FIFO (cpu -> stream)
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr;
  logic [DEPTH_LOG2-1:0] tx_rd_ptr;
  logic [DEPTH_LOG2:0]   tx_count;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  tx_push;
  logic                  tx_pop;

  assign tx_full  = (tx_count == COUNT_FULL);
  assign tx_empty = (tx_count == '0);
  // Full is judged on the pre-edge count, so a same-cycle pop does not make
  // room for a write arriving on a full FIFO.
  assign tx_push  = cpu_wren & ~tx_full;
  assign tx_pop   = out_ready & ~tx_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (tx_push && !tx_pop) begin
        tx_count <= tx_count + COUNT_ONE;
      end else if (tx_pop && !tx_push) begin
        tx_count <= tx_count - COUNT_ONE;
      end
    end
  end

  // Storage is deliberately not cleared by reset; the count alone decides
  // what is valid.
  always_ff @(posedge clock) begin
    if (tx_push && !reset) begin
      tx_mem[tx_wr_ptr] <= cpu_write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (stream -> cpu)
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr;
  logic [DEPTH_LOG2-1:0] rx_rd_ptr;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  rx_push;
  logic                  rx_pop;

  assign rx_full  = (rx_count == COUNT_FULL);
  assign rx_empty = (rx_count == '0);
  // No pass-through: a full RX refuses input even if the cpu pops this cycle,
  // and a push into an empty RX cannot be read back in the same cycle.
  assign rx_push  = in_valid & ~rx_full;
  assign rx_pop   = cpu_rden & ~rx_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (rx_push && !rx_pop) begin
        rx_count <= rx_count + COUNT_ONE;
      end else if (rx_pop && !rx_push) begin
        rx_count <= rx_count - COUNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push && !reset) begin
      rx_mem[rx_wr_ptr] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Reset forces the idle view immediately, even on the first cycle
  // of a mid-operation reset before the counts have been cleared.
  // ---------------------------------------------------------------------------
  assign out_valid      = ~reset & ~tx_empty;
  assign out_data       = out_valid ? tx_mem[tx_rd_ptr] : '0;
  assign cpu_write_full = ~reset & tx_full;

  assign cpu_read_empty = reset | rx_empty;
  assign cpu_read_data  = cpu_read_empty ? '0 : rx_mem[rx_rd_ptr];
  assign in_ready       = ~reset & ~rx_full;

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef IO_ENDPOINT_ERROR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (cpu_wren && tx_full)  overflow_q  <= 1'b1;
      if (cpu_rden && rx_empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q  & ~reset;
  assign underflow = underflow_q & ~reset;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_stream_endpoint.sv
module tb_io_port_stream_endpoint;

  localparam int W = 36;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_wren;
  logic [W-1:0] cpu_write_data;
  logic         cpu_write_full;
  logic         cpu_rden;
  logic [W-1:0] cpu_read_data;
  logic         cpu_read_empty;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         overflow;
  logic         underflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  io_port_stream_endpoint #(.WORD_WIDTH(W), .DEPTH(4), .DEPTH_LOG2(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_wren       (cpu_wren),
    .cpu_write_data (cpu_write_data),
    .cpu_write_full (cpu_write_full),
    .cpu_rden       (cpu_rden),
    .cpu_read_data  (cpu_read_data),
    .cpu_read_empty (cpu_read_empty),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  // Reference model: two bounded queues plus sticky flags.
  logic [W-1:0] m_tx[$];
  logic [W-1:0] m_rx[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wren, input logic [W-1:0] wdata,
                       input logic rden, input logic ordy, input logic ivld,
                       input logic [W-1:0] idata);
    reset          = rst;
    cpu_wren       = wren;
    cpu_write_data = wdata;
    cpu_rden       = rden;
    out_ready      = ordy;
    in_valid       = ivld;
    in_data        = idata;
  endtask

  task automatic compare_model(input string name);
    logic exp_ovf;
    logic exp_unf;
`ifdef IO_ENDPOINT_ERROR_FLAGS_EN
    exp_ovf = m_ovf & ~reset;
    exp_unf = m_unf & ~reset;
`else
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
`endif
    chk({name, ".full"},  W'(cpu_write_full), W'(!reset && m_tx.size() == 4));
    chk({name, ".ovld"},  W'(out_valid),      W'(!reset && m_tx.size() > 0));
    chk({name, ".odata"}, out_data,           (!reset && m_tx.size() > 0) ? m_tx[0] : '0);
    chk({name, ".empty"}, W'(cpu_read_empty), W'(reset || m_rx.size() == 0));
    chk({name, ".rdata"}, cpu_read_data,      (!reset && m_rx.size() > 0) ? m_rx[0] : '0);
    chk({name, ".irdy"},  W'(in_ready),       W'(!reset && m_rx.size() < 4));
    chk({name, ".ovf"},   W'(overflow),       W'(exp_ovf));
    chk({name, ".unf"},   W'(underflow),      W'(exp_unf));
  endtask

  // Applies the rules to the queues using the inputs present before the edge.
  task automatic model_update();
    bit tx_full_now;
    bit rx_full_now;
    bit rx_empty_now;
    if (reset) begin
      m_tx.delete();
      m_rx.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      tx_full_now  = (m_tx.size() == 4);
      rx_full_now  = (m_rx.size() == 4);
      rx_empty_now = (m_rx.size() == 0);
      if (cpu_wren && tx_full_now) m_ovf = 1'b1;
      if (out_ready && m_tx.size() > 0) void'(m_tx.pop_front());
      if (cpu_wren && !tx_full_now) m_tx.push_back(cpu_write_data);
      if (cpu_rden && rx_empty_now) m_unf = 1'b1;
      if (cpu_rden && !rx_empty_now) void'(m_rx.pop_front());
      if (in_valid && !rx_full_now) m_rx.push_back(in_data);
    end
  endtask

  task automatic settle(input string name);
    @(negedge clock);
    compare_model(name);
  endtask

  task automatic advance();
    model_update();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic         wren;
    logic [W-1:0] wdata;
    logic         rden;
    logic         ordy;
    logic         ivld;
    logic [W-1:0] idata;
    logic         e_full;
    logic         e_empty;
    logic         e_ovld;
    logic [W-1:0] e_odata;
    logic [W-1:0] e_rdata;
    logic         e_irdy;
  } vec_t;

  function automatic vec_t mk(logic rst, logic wren, logic [W-1:0] wdata, logic rden,
                              logic ordy, logic ivld, logic [W-1:0] idata,
                              logic e_full, logic e_empty, logic e_ovld,
                              logic [W-1:0] e_odata, logic [W-1:0] e_rdata, logic e_irdy);
    vec_t v;
    v.rst = rst; v.wren = wren; v.wdata = wdata; v.rden = rden; v.ordy = ordy;
    v.ivld = ivld; v.idata = idata; v.e_full = e_full; v.e_empty = e_empty;
    v.e_ovld = e_ovld; v.e_odata = e_odata; v.e_rdata = e_rdata; v.e_irdy = e_irdy;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //                 rst wr wdata rd ordy iv idata   full emp ovld odata rdata irdy
    tbl.push_back(mk(1, 1, 36'h99, 0, 0, 1, 36'h77,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 36'h99, 0, 0, 1, 36'h77,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 36'h99, 0, 0, 1, 36'h77,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 36'h0,  0, 0, 0, 36'h0,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 36'h1,  0, 0, 0, 36'h0,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 36'h2,  0, 0, 0, 36'h0,   0, 1, 1, 36'h1, 0, 1));
    tbl.push_back(mk(0, 1, 36'h3,  0, 0, 0, 36'h0,   0, 1, 1, 36'h1, 0, 1));
    tbl.push_back(mk(0, 1, 36'h4,  0, 0, 0, 36'h0,   0, 1, 1, 36'h1, 0, 1));
    tbl.push_back(mk(0, 1, 36'h5,  0, 0, 0, 36'h0,   1, 1, 1, 36'h1, 0, 1));
    tbl.push_back(mk(0, 0, 36'h0,  0, 1, 0, 36'h0,   1, 1, 1, 36'h1, 0, 1));
    tbl.push_back(mk(0, 0, 36'h0,  0, 1, 0, 36'h0,   0, 1, 1, 36'h2, 0, 1));
    tbl.push_back(mk(0, 0, 36'h0,  0, 1, 0, 36'h0,   0, 1, 1, 36'h3, 0, 1));
    tbl.push_back(mk(0, 0, 36'h0,  0, 1, 0, 36'h0,   0, 1, 1, 36'h4, 0, 1));
    tbl.push_back(mk(0, 0, 36'h0,  0, 1, 0, 36'h0,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 36'h0,  0, 0, 1, 36'hA,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 36'h0,  0, 0, 1, 36'hB,   0, 0, 0, 0, 36'hA, 1));
    tbl.push_back(mk(0, 0, 36'h0,  1, 0, 0, 36'h0,   0, 0, 0, 0, 36'hA, 1));
    tbl.push_back(mk(0, 0, 36'h0,  1, 0, 0, 36'h0,   0, 0, 0, 0, 36'hB, 1));
    tbl.push_back(mk(0, 0, 36'h0,  0, 0, 0, 36'h0,   0, 1, 0, 0, 0, 1));

    // Table-driven directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].wren, tbl[i].wdata, tbl[i].rden, tbl[i].ordy,
            tbl[i].ivld, tbl[i].idata);
      @(negedge clock);
      chk($sformatf("vec%0d.full", i),  W'(cpu_write_full), W'(tbl[i].e_full));
      chk($sformatf("vec%0d.empty", i), W'(cpu_read_empty), W'(tbl[i].e_empty));
      chk($sformatf("vec%0d.ovld", i),  W'(out_valid),      W'(tbl[i].e_ovld));
      chk($sformatf("vec%0d.odata", i), out_data,           tbl[i].e_odata);
      chk($sformatf("vec%0d.rdata", i), cpu_read_data,      tbl[i].e_rdata);
      chk($sformatf("vec%0d.irdy", i),  W'(in_ready),       W'(tbl[i].e_irdy));
      compare_model($sformatf("vec%0d", i));
      advance();
    end
`ifdef IO_ENDPOINT_ERROR_FLAGS_EN
    chk("overflow_sticky", W'(overflow), W'(1'b1));
`else
    chk("overflow_tied", W'(overflow), W'(1'b0));
`endif

    // RX at count 2 with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1, W'(36'h100 + i));
      settle("rx_prefill");
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, 0, 1, W'(36'h102 + i));
      settle("rx_stream");
      chk($sformatf("rx_stream%0d.rdata", i), cpu_read_data, W'(36'h100 + i));
      chk($sformatf("rx_stream%0d.empty", i), W'(cpu_read_empty), W'(1'b0));
      advance();
    end

    // Fill RX, then offer with a same-cycle pop: no pass-through
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1, W'(36'h108 + i));
      settle("rx_fill");
      advance();
    end
    drive(0, 0, 0, 1, 0, 1, 36'h10A);
    settle("rx_full_pop");
    chk("rx_full_pop.irdy", W'(in_ready), W'(1'b0));
    chk("rx_full_pop.rdata", cpu_read_data, 36'h106);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    settle("rx_after_pop");
    chk("rx_after_pop.irdy", W'(in_ready), W'(1'b1));
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      settle("rx_drain");
      advance();
    end

    // Read on empty, then push into empty with a same-cycle read
    drive(0, 0, 0, 1, 0, 0, 0);
    settle("rx_underflow");
    chk("rx_underflow.rdata", cpu_read_data, '0);
    advance();
    drive(0, 0, 0, 1, 0, 1, 36'h200);
    settle("rx_push_empty");
    chk("rx_push_empty.rdata", cpu_read_data, '0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    settle("rx_retained");
    chk("rx_retained.rdata", cpu_read_data, 36'h200);
`ifdef IO_ENDPOINT_ERROR_FLAGS_EN
    chk("underflow_sticky", W'(underflow), W'(1'b1));
`else
    chk("underflow_tied", W'(underflow), W'(1'b0));
`endif
    advance();

    // Mid-operation reset discards queued words in both FIFOs
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, W'(36'h300 + i), 0, 0, 1, W'(36'h400 + i));
      settle("pre_reset_load");
      advance();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    settle("mid_reset");
    chk("mid_reset.ovld", W'(out_valid), W'(1'b0));
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    settle("post_reset");
    chk("post_reset.empty", W'(cpu_read_empty), W'(1'b1));
    chk("post_reset.ovld", W'(out_valid), W'(1'b0));
    advance();

    // Randomized traffic against the queue model
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 79) == 0,
            $urandom_range(0, 1) == 1, {4'($urandom), 32'($urandom)},
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, {4'($urandom), 32'($urandom)});
      settle($sformatf("rand%0d", i));
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
